// File: rtl/alu_wide_sequencer_pkg.sv
// Shared encodings for the wide-ALU byte sequencer: FSM states and the ALU
// select-class bit (S[2]) that separates arithmetic from logic operations.
package alu_wide_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam logic ALU_ARITH = 1'b0;
    localparam logic ALU_LOGIC = 1'b1;

endpackage

// File: rtl/alu_wide_sequencer.sv
// Slices one multi-byte op into LSB-first bytes for an external 8-bit ALU, chaining carry.
// Latency: result valid WORDS cycles after the accept edge; one op per WORDS+2 cycles.
// Backpressure: op_ready only in IDLE; result held in DONE until res_ready.
module alu_wide_sequencer
    import alu_wide_sequencer_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic [2:0]           op_sel,
    input  logic                 op_cin,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic                 alu_cin,
    output logic [2:0]           alu_s,
    input  logic [7:0]           alu_data,
    input  logic                 alu_cout,
    input  logic                 alu_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*WORDS-1:0]   res_data,
    output logic                 res_cout,
    output logic                 res_ovf,
    output logic                 res_zero
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    seq_state_t              state, state_nxt;
    logic [IW-1:0]           idx;
    logic [WORDS-1:0][7:0]   a_q, b_q, res_q;
    logic [2:0]              sel_q;
    logic                    cin_q;
    logic                    carry_q;
    logic                    res_cout_q;
    logic                    res_ovf_q;
    logic                    last_byte;
    logic                    is_arith;

    assign last_byte = (idx == LAST_IDX);
    assign is_arith  = (sel_q[2] == ALU_ARITH);

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last_byte) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Only byte 0 of an arithmetic op takes the external carry; logic ops reuse op_cin as a sub-select.
    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_s   = 3'b000;
        alu_cin = 1'b0;
        if (state == ST_RUN) begin
            alu_a   = a_q[idx];
            alu_b   = b_q[idx];
            alu_s   = sel_q;
            alu_cin = (is_arith && idx != '0) ? carry_q : cin_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= 3'b000;
            cin_q      <= 1'b0;
            carry_q    <= 1'b0;
            res_q      <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        sel_q <= op_sel;
                        cin_q <= op_cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    res_q[idx] <= alu_data;
                    carry_q    <= alu_cout;
                    if (last_byte) begin
                        res_cout_q <= is_arith & alu_cout;
                        res_ovf_q  <= is_arith & alu_ovf;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_data = res_q;
    assign res_cout = res_cout_q;
    assign res_ovf  = res_ovf_q;
    assign res_zero = ~|res_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer (WORDS=2) wired to a behavioural 8-bit ALU.
// Logic ops deliberately return Cout/Ovf=1 so the sequencer's flag masking is observable.
module tb_alu_wide_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a, op_b;
    logic [2:0]  op_sel;
    logic        op_cin;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [2:0]  alu_s;
    logic [7:0]  alu_data;
    logic        alu_cout;
    logic        alu_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_cout;
    logic        res_ovf;
    logic        res_zero;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer #(.WORDS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .op_cin    (op_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_s     (alu_s),
        .alu_data  (alu_data),
        .alu_cout  (alu_cout),
        .alu_ovf   (alu_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .res_zero  (res_zero)
    );

    // Behavioural ALU: arith S[1:0] picks B, ~B, 0, FF as the addend; logic uses {S[1:0],Cin}.
    logic [7:0] addend;
    logic [8:0] sum;
    always_comb begin
        addend   = 8'h00;
        sum      = 9'h000;
        alu_data = 8'h00;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        if (alu_s[2] == 1'b0) begin
            case (alu_s[1:0])
                2'b00:   addend = alu_b;
                2'b01:   addend = ~alu_b;
                2'b10:   addend = 8'h00;
                default: addend = 8'hFF;
            endcase
            sum      = {1'b0, alu_a} + {1'b0, addend} + {8'h00, alu_cin};
            alu_data = sum[7:0];
            alu_cout = sum[8];
            alu_ovf  = (alu_a[7] == addend[7]) && (sum[7] != alu_a[7]);
        end else begin
            case ({alu_s[1:0], alu_cin})
                3'b000:  alu_data = alu_a & alu_b;
                3'b001:  alu_data = alu_a | alu_b;
                3'b010:  alu_data = alu_a ^ alu_b;
                3'b011:  alu_data = ~(alu_a ^ alu_b);
                3'b100:  alu_data = alu_a;
                3'b101:  alu_data = alu_b;
                3'b110:  alu_data = ~alu_a;
                default: alu_data = ~alu_b;
            endcase
            alu_cout = 1'b1;
            alu_ovf  = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, checks per-byte ALU drive, and leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] sel, input logic cin, input logic exp_cin1,
                          input logic [15:0] exp_data, input logic exp_cout,
                          input logic exp_ovf, input logic exp_zero);
        op_a = a; op_b = b; op_sel = sel; op_cin = cin; op_valid = 1'b1;
        check({tag, ".op_ready"}, 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        check({tag, ".b0_busy"},  32'(op_ready),  32'd0);
        check({tag, ".b0_vld"},   32'(res_valid), 32'd0);
        check({tag, ".b0_ab"},    {16'h0, alu_a, alu_b}, {16'h0, a[7:0], b[7:0]});
        check({tag, ".b0_s"},     32'(alu_s),   32'(sel));
        check({tag, ".b0_cin"},   32'(alu_cin), 32'(cin));
        tick();
        check({tag, ".b1_vld"},   32'(res_valid), 32'd0);
        check({tag, ".b1_ab"},    {16'h0, alu_a, alu_b}, {16'h0, a[15:8], b[15:8]});
        check({tag, ".b1_cin"},   32'(alu_cin), 32'(exp_cin1));
        tick();
        check({tag, ".vld"},  32'(res_valid), 32'd1);
        check({tag, ".data"}, 32'(res_data),  32'(exp_data));
        check({tag, ".cout"}, 32'(res_cout),  32'(exp_cout));
        check({tag, ".ovf"},  32'(res_ovf),   32'(exp_ovf));
        check({tag, ".zero"}, 32'(res_zero),  32'(exp_zero));
        check({tag, ".idle_drv"}, {13'h0, alu_cin, alu_s, alu_a, alu_b}, 32'd0);
    endtask

    task automatic finish_op(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, ".ret_rdy"}, 32'(op_ready),  32'd1);
        check({tag, ".ret_vld"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        logic saw_vld;
        rst_n = 1'b0; op_valid = 1'b1; res_ready = 1'b0;
        op_a = 16'h1234; op_b = 16'h4321; op_sel = 3'b000; op_cin = 1'b0;

        // Reset with a pending request: must stay idle and cleared.
        tick();
        tick();
        check("rst.op_ready",  32'(op_ready),  32'd1);
        check("rst.res_valid", 32'(res_valid), 32'd0);
        check("rst.res_data",  32'(res_data),  32'd0);
        check("rst.flags",     {30'h0, res_cout, res_ovf}, 32'd0);
        check("rst.alu_drv",   {13'h0, alu_cin, alu_s, alu_a, alu_b}, 32'd0);
        op_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst.still_idle", 32'(op_ready), 32'd1);

        run_op("add_carry", 16'h00FF, 16'h0001, 3'b000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        finish_op("add_carry");
        run_op("add_ovf",   16'h7FFF, 16'h0001, 3'b000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        finish_op("add_ovf");
        run_op("add_wrap",  16'hFFFF, 16'h0001, 3'b000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        finish_op("add_wrap");
        run_op("add_cin",   16'h1234, 16'h1111, 3'b000, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0);
        finish_op("add_cin");
        run_op("log_xnor",  16'hF0F0, 16'h0FF0, 3'b101, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        finish_op("log_xnor");
        run_op("log_notb",  16'hF0F0, 16'h0FF0, 3'b111, 1'b1, 1'b1, 16'hF00F, 1'b0, 1'b0, 1'b0);
        finish_op("log_notb");
        run_op("log_and",   16'hF0F0, 16'h0FF0, 3'b100, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
        finish_op("log_and");

        // Hold DONE under backpressure while another request waits.
        run_op("stall", 16'h0102, 16'h0304, 3'b000, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b0);
        op_a = 16'hAAAA; op_b = 16'h5555; op_sel = 3'b000; op_cin = 1'b0; op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall.vld%0d", i),  32'(res_valid), 32'd1);
            check($sformatf("stall.data%0d", i), 32'(res_data),  32'h0406);
            check($sformatf("stall.rdy%0d", i),  32'(op_ready),  32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("stall.release_rdy", 32'(op_ready),  32'd1);
        check("stall.release_vld", 32'(res_valid), 32'd0);
        run_op("post_stall", 16'hAAAA, 16'h5555, 3'b000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        finish_op("post_stall");

        // Reset after byte 0 of an ADD: op discarded, no result.
        op_a = 16'h00FF; op_b = 16'h0001; op_sel = 3'b000; op_cin = 1'b0; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort.op_ready", 32'(op_ready),  32'd1);
        check("abort.res_vld",  32'(res_valid), 32'd0);
        check("abort.res_data", 32'(res_data),  32'd0);
        saw_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_vld = saw_vld | res_valid;
        end
        check("abort.no_vld", 32'(saw_vld), 32'd0);
        run_op("after_abort", 16'h8000, 16'h8000, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        finish_op("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
